// File: rtl/iob_fifo_sync_ctrl_if.sv
// Consumer-side port bundle of the synchronous FIFO controller.
// master = user logic, slave = FIFO controller.
interface iob_fifo_sync_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_full;
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;

    modport master (
        output w_en,
        output w_data,
        output r_en,
        input  w_full,
        input  r_data,
        input  r_valid,
        input  r_empty,
        input  level,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  w_en,
        input  w_data,
        input  r_en,
        output w_full,
        output r_data,
        output r_valid,
        output r_empty,
        output level,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/iob_fifo_sync_ctrl.sv
// Single-clock FIFO controller driving an external two-port RAM.
// Pointers, level and flags are registered; RAM ports are combinational.
module iob_fifo_sync_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    iob_fifo_sync_ctrl_if.slave    fifo,
    output logic                   ext_mem_w_en,
    output logic [ADDR_W-1:0]      ext_mem_w_addr,
    output logic [DATA_W-1:0]      ext_mem_w_data,
    output logic                   ext_mem_r_en,
    output logic [ADDR_W-1:0]      ext_mem_r_addr,
    input  logic [DATA_W-1:0]      ext_mem_r_data
);

    localparam int LW = ADDR_W + 1;
    localparam logic [LW-1:0] DEPTH = LW'(1 << ADDR_W);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              w_full_q, w_full_d;
    logic              r_empty_q, r_empty_d;
    logic              r_valid_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wacc;
    logic              racc;

    // Acceptance is gated by the registered flags, so both may fire together
    // only when the FIFO is neither full nor empty.
    assign wacc = fifo.w_en & ~w_full_q & ~rst;
    assign racc = fifo.r_en & ~r_empty_q & ~rst;

    assign ext_mem_w_en   = wacc;
    assign ext_mem_w_addr = wptr_q;
    assign ext_mem_w_data = fifo.w_data;
    assign ext_mem_r_en   = racc;
    assign ext_mem_r_addr = rptr_q;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q + LW'(wacc) - LW'(racc);
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wacc) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (racc) begin
            rptr_d = rptr_q + ADDR_W'(1);
        end
        if (fifo.w_en & w_full_q) begin
            overflow_d = 1'b1;
        end
        if (fifo.r_en & r_empty_q) begin
            underflow_d = 1'b1;
        end
        w_full_d  = (level_d == DEPTH);
        r_empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            w_full_q    <= 1'b0;
            r_empty_q   <= 1'b1;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            w_full_q    <= w_full_d;
            r_empty_q   <= r_empty_d;
            r_valid_q   <= racc;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo.w_full    = w_full_q;
    assign fifo.r_empty   = r_empty_q;
    assign fifo.r_valid   = r_valid_q;
    assign fifo.level     = level_q;
    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;
    assign fifo.r_data    = ext_mem_r_data;

endmodule

// File: tb/tb_iob_fifo_sync_ctrl.sv
// Directed bench for iob_fifo_sync_ctrl with a behavioural 16x8 RAM.
// Expected data comes from a queue of words the bench chose to push.
module tb_iob_fifo_sync_ctrl;

    logic       clk;
    logic       rst;
    logic       ext_mem_w_en;
    logic [3:0] ext_mem_w_addr;
    logic [7:0] ext_mem_w_data;
    logic       ext_mem_r_en;
    logic [3:0] ext_mem_r_addr;
    logic [7:0] ext_mem_r_data;
    logic [7:0] mem [16];

    int total = 0;
    int bad = 0;
    logic [3:0] wa;
    logic [3:0] ra;
    logic [7:0] q [$];

    iob_fifo_sync_ctrl_if #(.DATA_W(8), .ADDR_W(4)) fif ();

    iob_fifo_sync_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo           (fif),
        .ext_mem_w_en   (ext_mem_w_en),
        .ext_mem_w_addr (ext_mem_w_addr),
        .ext_mem_w_data (ext_mem_w_data),
        .ext_mem_r_en   (ext_mem_r_en),
        .ext_mem_r_addr (ext_mem_r_addr),
        .ext_mem_r_data (ext_mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ext_mem_w_en) mem[ext_mem_w_addr] <= ext_mem_w_data;
        if (ext_mem_r_en) ext_mem_r_data <= mem[ext_mem_r_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus; wok/rok say whether push/pop must be accepted.
    task automatic cyc(bit we, logic [7:0] wd, bit re, bit wok, bit rok);
        logic [7:0] e;
        fif.w_en   = we;
        fif.w_data = wd;
        fif.r_en   = re;
        #1;
        chk("mem_w_en", ext_mem_w_en, wok);
        if (wok) chk("mem_w_addr", ext_mem_w_addr, wa);
        if (wok) chk("mem_w_data", ext_mem_w_data, wd);
        chk("mem_r_en", ext_mem_r_en, rok);
        if (rok) chk("mem_r_addr", ext_mem_r_addr, ra);
        step();
        fif.w_en = 1'b0;
        fif.r_en = 1'b0;
        chk("r_valid", fif.r_valid, rok);
        if (rok) begin
            e = q.pop_front();
            chk("r_data", fif.r_data, e);
            ra = ra + 4'd1;
        end
        if (wok) begin
            q.push_back(wd);
            wa = wa + 4'd1;
        end
    endtask

    initial begin
        wa = '0;
        ra = '0;
        rst = 1'b1;
        fif.w_en = 1'b0;
        fif.w_data = '0;
        fif.r_en = 1'b0;
        repeat (2) step();
        fif.w_en = 1'b1;
        fif.r_en = 1'b1;
        #1;
        chk("rst_mem_w_en", ext_mem_w_en, 0);
        chk("rst_mem_r_en", ext_mem_r_en, 0);
        chk("rst_empty", fif.r_empty, 1);
        chk("rst_full", fif.w_full, 0);
        chk("rst_level", fif.level, 0);
        chk("rst_valid", fif.r_valid, 0);
        chk("rst_ovf", fif.overflow, 0);
        chk("rst_udf", fif.underflow, 0);
        step();
        chk("rst_hold_udf", fif.underflow, 0);
        fif.w_en = 1'b0;
        fif.r_en = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) cyc(1, 8'(32 + i), 0, 1, 0);
        chk("fill_level", fif.level, 16);
        chk("fill_full", fif.w_full, 1);
        chk("fill_empty", fif.r_empty, 0);

        cyc(1, 8'hAA, 0, 0, 0);
        chk("ovf_set", fif.overflow, 1);
        chk("ovf_level", fif.level, 16);

        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0, 1);
        chk("drain_level", fif.level, 0);
        chk("drain_empty", fif.r_empty, 1);
        chk("drain_full", fif.w_full, 0);

        cyc(0, 8'h00, 1, 0, 0);
        chk("udf_set", fif.underflow, 1);
        chk("udf_ovf_sticky", fif.overflow, 1);

        cyc(1, 8'h11, 1, 1, 0);
        chk("both_empty_level", fif.level, 1);
        chk("both_empty_flag", fif.r_empty, 0);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h12 + i), 0, 1, 0);
        chk("lvl5", fif.level, 5);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'(8'h16 + i), 1, 1, 1);
            chk("both_mid_level", fif.level, 5);
        end
        for (int i = 0; i < 11; i++) cyc(1, 8'(8'h20 + i), 0, 1, 0);
        chk("refill_full", fif.w_full, 1);
        cyc(1, 8'hEE, 1, 0, 1);
        chk("both_full_level", fif.level, 15);
        chk("both_full_flag", fif.w_full, 0);
        for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0, 1);
        chk("drain2_empty", fif.r_empty, 1);
        chk("flags_sticky_o", fif.overflow, 1);
        chk("flags_sticky_u", fif.underflow, 1);

        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) cyc(1, 8'(32 + p * 16 + i), 0, 1, 0);
            chk("wrap_full", fif.w_full, 1);
            for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0, 1);
            chk("wrap_empty", fif.r_empty, 1);
        end

        for (int i = 0; i < 7; i++) cyc(1, 8'(8'h70 + i), 0, 1, 0);
        chk("mid_level7", fif.level, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wa = '0;
        ra = '0;
        q.delete();
        chk("mid_rst_level", fif.level, 0);
        chk("mid_rst_empty", fif.r_empty, 1);
        chk("mid_rst_ovf", fif.overflow, 0);
        chk("mid_rst_udf", fif.underflow, 0);
        cyc(1, 8'h55, 0, 1, 0);
        cyc(0, 8'h00, 1, 0, 1);
        chk("final_level", fif.level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
